fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 15 +
 rtl/fifo_wr_arb_rr_pick.sv | 34 +++
 rtl/fifo_wr_arb.sv | 164 ++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings and
// default parameter values.
package fifo_wr_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin picker: first requester at or after last_owner+1 (mod N_REQ).
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = (DEF_N_REQ > 1) ? $clog2(DEF_N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;

    // Rotating priority scan, first hit wins
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s         = IW'((32'(last_owner) + 32'(k)) % 32'(N_REQ));
            hit_s         = !found_s && req[idx_s];
            winner[idx_s] = winner[idx_s] | hit_s;
            found_s       = found_s | hit_s;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// with bounded bursts and a reserved-entry level counter for back-pressure.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     fifo_write,
    output logic [DW-1:0]            fifo_data_in,
    input  logic                     fifo_read,
    input  logic                     fifo_ready,
    input  logic                     fifo_overflow,
    output logic [$clog2(DEPTH)-1:0] level,
    output logic                     full,
    output logic                     err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int LW = $clog2(DEPTH);

    arb_state_e      state_r;
    logic [IW-1:0]   owner_r;
    logic [IW-1:0]   last_owner_r;
    logic [BW-1:0]   beat_cnt_r;
    logic [LW-1:0]   level_r;
    logic            fifo_write_r;
    logic [DW-1:0]   fifo_data_in_r;
    logic            err_r;

    logic [N_REQ-1:0] pick_s;
    logic             pick_valid_s;
    logic [IW-1:0]    pick_idx_s;
    logic [N_REQ-1:0] gnt_s;
    logic [DW-1:0]    owner_data_s;
    logic             full_s;
    logic             accept_s;
    logic             pop_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_r),
        .winner     (pick_s),
        .valid      (pick_valid_s)
    );

    assign full_s   = (level_r == LW'(DEPTH - 1));
    assign accept_s = |(gnt_s & req);
    assign pop_s    = fifo_read && fifo_ready;

    // One-hot winner to index, and owner's data slice
    always_comb begin
        pick_idx_s   = '0;
        owner_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_idx_s   = pick_idx_s | (pick_s[i] ? IW'(i) : IW'(0));
            owner_data_s = owner_data_s | ((owner_r == IW'(i)) ? data[i*DW +: DW] : DW'(0));
        end
    end

    // Grant follows the owner's request live, gated by full
    always_comb begin
        gnt_s = '0;
        if (state_r == ST_BURST) begin
            gnt_s[owner_r] = req[owner_r] && !full_s;
        end else begin
            gnt_s = '0;
        end
    end

    // Arbitration FSM: one-cycle ARB bubble, then bounded BURST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_ARB;
            owner_r      <= '0;
            last_owner_r <= IW'(N_REQ - 1);
            beat_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_ARB: begin
                    if (pick_valid_s && !full_s) begin
                        owner_r    <= pick_idx_s;
                        beat_cnt_r <= '0;
                        state_r    <= ST_BURST;
                    end else begin
                        state_r    <= ST_ARB;
                    end
                end
                ST_BURST: begin
                    if (!req[owner_r]) begin
                        state_r      <= ST_ARB;
                        last_owner_r <= owner_r;
                    end else if (accept_s && (beat_cnt_r == BW'(MAX_BURST - 1))) begin
                        state_r      <= ST_ARB;
                        last_owner_r <= owner_r;
                    end else if (accept_s) begin
                        beat_cnt_r   <= beat_cnt_r + BW'(1);
                    end else begin
                        beat_cnt_r   <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_ARB;
                end
            endcase
        end
    end

    // Registered write strobe and data; data holds between beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_write_r   <= 1'b0;
            fifo_data_in_r <= '0;
        end else begin
            fifo_write_r <= accept_s;
            if (accept_s) begin
                fifo_data_in_r <= owner_data_s;
            end else begin
                fifo_data_in_r <= fifo_data_in_r;
            end
        end
    end

    // Reserved-entry count: bumps at acceptance, before the write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= '0;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= (level_r != '0) ? level_r - LW'(1) : level_r;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | fifo_overflow | (pop_s && (level_r == '0));
        end
    end

    assign gnt          = gnt_s;
    assign fifo_write   = fifo_write_r;
    assign fifo_data_in = fifo_data_in_r;
    assign level        = level_r;
    assign full         = full_s;
    assign err          = err_r;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a small FIFO model on the write port.
module tb_fifo_wr_arb;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] data;
    logic [N_REQ-1:0]    gnt;
    logic                fifo_write;
    logic [DW-1:0]       fifo_data_in;
    logic                fifo_read;
    logic                fifo_ready;
    logic                fifo_overflow;
    logic [LW-1:0]       level;
    logic                full;
    logic                err;

    logic                ovf_force;
    logic                rdy_force;
    logic                model_pop;
    logic                model_ovf;
    int                  occ;
    int                  ovf_cnt = 0;
    logic [DW-1:0]       wr_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .data          (data),
        .gnt           (gnt),
        .fifo_write    (fifo_write),
        .fifo_data_in  (fifo_data_in),
        .fifo_read     (fifo_read),
        .fifo_ready    (fifo_ready),
        .fifo_overflow (fifo_overflow),
        .level         (level),
        .full          (full),
        .err           (err)
    );

    assign model_pop     = fifo_read && (occ != 0);
    assign model_ovf     = fifo_write && (occ == DEPTH - 1) && !model_pop;
    assign fifo_ready    = (occ != 0) || rdy_force;
    assign fifo_overflow = ovf_force || model_ovf;

    // FIFO model: occupancy plus a log of every stored word
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= 0;
        end else begin
            if (fifo_write && !model_ovf) wr_q.push_back(fifo_data_in);
            if (model_ovf) ovf_cnt <= ovf_cnt + 1;
            occ <= occ + ((fifo_write && !model_ovf) ? 1 : 0) - (model_pop ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        data      = '0;
        fifo_read = 1'b0;
        ovf_force = 1'b0;
        rdy_force = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_level(input int tgt, input string tag);
        for (int i = 0; i < 20 && level != LW'(tgt); i++) tick();
        chk(tag, 32'(level), 32'(tgt));
    endtask

    // Producer 2 drops after two beats; next grant goes to exp_g
    task automatic drop_case(input logic [N_REQ-1:0] nxt, input logic [N_REQ-1:0] exp_g,
                             input string tag);
        do_reset();
        fifo_read = 1'b1;
        req       = 4'b0100;
        tick();
        chk({tag, "_burst"}, 32'(gnt), 32'h4);
        tick();
        tick();
        req = nxt;
        #1;
        chk({tag, "_drop"}, 32'(gnt), 32'h0);
        tick();
        chk({tag, "_arb"}, 32'(gnt), 32'h0);
        tick();
        chk({tag, "_next"}, 32'(gnt), 32'(exp_g));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int base;
        int ovf0;
        logic acc;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_write", 32'(fifo_write), 32'h0);
        chk("rst_data", 32'(fifo_data_in), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Single producer, ten beats offered, no reads: seven fit
        do_reset();
        base = wr_q.size();
        ovf0 = ovf_cnt;
        idx  = 0;
        for (int c = 0; c < 30; c++) begin
            req       = (idx < 10) ? 4'b0001 : 4'b0000;
            data[7:0] = 8'(idx + 1);
            #1;
            acc = gnt[0] & req[0];
            tick();
            if (acc) idx++;
        end
        chk("single_beats", 32'(idx), 32'd7);
        chk("single_nwr", 32'(wr_q.size() - base), 32'd7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("single_wr%0d", k), 32'(wr_q[base + k]), 32'(k + 1));
        end
        chk("single_level", 32'(level), 32'd7);
        chk("single_full", 32'(full), 32'h1);
        chk("single_gnt", 32'(gnt), 32'h0);
        chk("single_ovf", 32'(ovf_cnt - ovf0), 32'h0);
        chk("single_err", 32'(err), 32'h0);

        // All four requesting, consumer reading every cycle
        do_reset();
        base      = wr_q.size();
        fifo_read = 1'b1;
        req       = 4'b1111;
        data      = 32'hA3A2A1A0;
        for (int c = 0; c < 25; c++) begin
            #1;
            chk($sformatf("rr_c%0d", c), 32'(gnt),
                (c % 5 == 0) ? 32'h0 : (32'h1 << ((c / 5) % 4)));
            @(posedge clk);
        end
        #1;
        req = '0;
        repeat (3) tick();
        chk("rr_nwr", 32'(wr_q.size() - base), 32'd20);
        for (int k = 0; k < 20; k += 4) begin
            chk($sformatf("rr_wr%0d", k), 32'(wr_q[base + k]), 32'hA0 + 32'((k / 4) % 4));
        end
        chk("rr_err", 32'(err), 32'h0);

        // Simultaneous push and pop at level 3
        do_reset();
        req  = 4'b0010;
        data = 32'h00005500;
        wait_level(3, "pp_reach3");
        fifo_read = 1'b1;
        #1;
        chk("pp_gnt", 32'(gnt), 32'h2);
        chk("pp_ready", 32'(fifo_ready), 32'h1);
        tick();
        chk("pp_level", 32'(level), 32'd3);
        fifo_read = 1'b0;
        req       = '0;

        // Early drop: next grant to 3 if requesting, else wrap to 0
        drop_case(4'b1000, 4'b1000, "drop3");
        drop_case(4'b0001, 4'b0001, "drop0");

        // Reset mid-burst at level 5
        do_reset();
        req  = 4'b0001;
        data = 32'h00000077;
        wait_level(5, "mid_reach5");
        chk("mid_gnt_pre", 32'(gnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_level", 32'(level), 32'h0);
        chk("mid_gnt", 32'(gnt), 32'h0);
        chk("mid_write", 32'(fifo_write), 32'h0);
        req = 4'b1111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mid_write_after", 32'(fifo_write), 32'h0);
        chk("mid_restart", 32'(gnt), 32'h1);

        // Forced overflow sets a sticky error
        do_reset();
        ovf_force = 1'b1;
        tick();
        ovf_force = 1'b0;
        chk("ovf_err", 32'(err), 32'h1);
        repeat (3) tick();
        chk("ovf_sticky", 32'(err), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("ovf_clear", 32'(err), 32'h0);

        // Pop while level is zero
        do_reset();
        #1;
        chk("pop0_pre", 32'(err), 32'h0);
        fifo_read = 1'b1;
        rdy_force = 1'b1;
        tick();
        fifo_read = 1'b0;
        rdy_force = 1'b0;
        chk("pop0_err", 32'(err), 32'h1);
        chk("pop0_level", 32'(level), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
